// File: rtl/window_deserializer.sv
// Receive side of the window stream: reassembles BEATS beats into one detection window
// and checks that every beat carries the same metadata as beat 0.
//
// state   | meaning
// COLLECT | accepting beats 0..BEATS-1; window_valid low
// FULL    | window held for downstream; next beat 0 may overlap the handshake
module window_deserializer #(
  parameter int WINDOW_WIDTH = 1152,
  parameter int BUS_WIDTH    = 128,
  parameter int META_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stream_valid,
  input  logic [BUS_WIDTH-1:0]    stream,
  output logic                    stream_ready,
  output logic                    window_valid,
  input  logic                    window_ready,
  output logic [WINDOW_WIDTH-1:0] window,
  output logic [META_WIDTH-1:0]   metadata,
  output logic                    meta_error
);

  localparam int DATA_PORTION = BUS_WIDTH - META_WIDTH;
  localparam int BEATS        = (WINDOW_WIDTH + DATA_PORTION - 1) / DATA_PORTION;
  localparam int REMAIN       = WINDOW_WIDTH - (BEATS - 1) * DATA_PORTION;
  localparam int CNT_W        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [WINDOW_WIDTH-1:0] window_q, window_d;
  logic [META_WIDTH-1:0]   metadata_q, metadata_d;
  logic                    meta_error_q, meta_error_d;

  logic                    accept;
  logic                    wr_en;
  logic [CNT_W-1:0]        wr_idx;
  logic [META_WIDTH-1:0]   beat_meta;
  logic [DATA_PORTION-1:0] beat_data;

  assign beat_meta = stream[BUS_WIDTH-1 -: META_WIDTH];
  assign beat_data = stream[DATA_PORTION-1:0];

  // In FULL the only beat we can take is the next window's beat 0, and only when
  // the held window leaves in the same cycle.
  assign stream_ready = (state_q == COLLECT) ? 1'b1 : window_ready;
  assign accept       = stream_valid && stream_ready;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    metadata_d   = metadata_q;
    meta_error_d = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = beat_cnt_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          if (beat_cnt_q == '0) begin
            metadata_d = beat_meta;
          end else if (beat_meta != metadata_q) begin
            meta_error_d = 1'b1;
          end
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = FULL;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (window_ready) begin
          state_d    = COLLECT;
          beat_cnt_d = '0;
          if (stream_valid) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            metadata_d = beat_meta;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Last beat only carries REMAIN meaningful bits; the rest of its slice is padding.
  always_comb begin
    window_d = window_q;
    for (int k = 0; k < BEATS - 1; k++) begin
      if (wr_en && (wr_idx == CNT_W'(k))) begin
        window_d[k*DATA_PORTION +: DATA_PORTION] = beat_data;
      end
    end
    if (wr_en && (wr_idx == LAST_BEAT)) begin
      window_d[(BEATS-1)*DATA_PORTION +: REMAIN] = beat_data[REMAIN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= COLLECT;
      beat_cnt_q   <= '0;
      window_q     <= '0;
      metadata_q   <= '0;
      meta_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      window_q     <= window_d;
      metadata_q   <= metadata_d;
      meta_error_q <= meta_error_d;
    end
  end

  assign window_valid = (state_q == FULL);
  assign window       = window_q;
  assign metadata     = metadata_q;
  assign meta_error   = meta_error_q;

endmodule

// File: tb/tb_window_deserializer.sv
// Self-checking bench for window_deserializer: a serializer model drives beats,
// a scoreboard queue holds expected windows, a negedge monitor compares.
module tb_window_deserializer;

  logic          clk = 1'b0;
  logic          rst;
  logic          stream_valid;
  logic [127:0]  stream;
  logic          stream_ready;
  logic          window_valid;
  logic          window_ready;
  logic [1151:0] window;
  logic [3:0]    metadata;
  logic          meta_error;

  window_deserializer dut (
    .clk(clk), .rst(rst), .stream_valid(stream_valid), .stream(stream),
    .stream_ready(stream_ready), .window_valid(window_valid), .window_ready(window_ready),
    .window(window), .metadata(metadata), .meta_error(meta_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1151:0] w;
    logic [3:0]    m;
  } exp_t;

  typedef struct {
    logic [3:0] meta;
    int         bad_k;
    logic [3:0] bad_meta;
    logic       pad;
    int         exp_errs;
  } vec_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            err_pulses = 0;
  int            last_hs = 0;
  bit            have_prev = 0;
  bit            chk_period = 0;
  logic [1151:0] last_win = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_win(input string name, input logic [1151:0] act, input logic [1151:0] exp);
    int first_bad;
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      first_bad = 0;
      for (int i = 8; i >= 0; i--) if (act[i*128 +: 128] !== exp[i*128 +: 128]) first_bad = i;
      $display("FAIL %s: chunk %0d got %h, expected %h", name, first_bad,
               act[first_bad*128 +: 128], exp[first_bad*128 +: 128]);
    end
  endtask

  function automatic logic [1151:0] rand_win();
    logic [1151:0] w;
    for (int i = 0; i < 36; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Serializer model: beat k carries window bits k*124.. ; last beat 36 bits + padding.
  function automatic logic [127:0] mk_beat(input logic [1151:0] w, input logic [3:0] m,
                                            input int k, input logic pad);
    logic [123:0] d;
    if (k < 9) d = w[k*124 +: 124];
    else begin
      d = pad ? {124{1'b1}} : '0;
      d[35:0] = w[1151:1116];
    end
    return {m, d};
  endfunction

  task automatic send_beat(input logic [127:0] b);
    bit done;
    done = 0;
    stream_valid = 1'b1;
    stream = b;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (stream_ready) done = 1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_beat: stream_ready stayed 0, expected 1 within 100 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_window(input logic [1151:0] w, input logic [3:0] m, input int first,
                             input int last, input int bad_k, input logic [3:0] bad_m,
                             input logic pad);
    for (int k = first; k <= last; k++)
      send_beat(mk_beat(w, (k == bad_k) ? bad_m : m, k, pad));
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(negedge clk);
    chk("drain", 128'(sb_q.size()), 128'd0);
  endtask

  // Monitor: reference beat counter, meta_error model, valid timing, scoreboard pop.
  int         m_idx = 0;
  logic [3:0] m_meta0 = '0;
  bit         exp_err = 0;
  bit         exp_valid = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      m_idx = 0;
      exp_err = 0;
      exp_valid = 0;
    end else begin
      if (exp_err || meta_error) chk("meta_error", 128'(meta_error), 128'(exp_err));
      if (meta_error) err_pulses++;
      if (exp_valid) chk("valid_rise", 128'(window_valid), 128'd1);
      exp_err = 0;
      exp_valid = 0;
      if (window_valid && window_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_window", 128'(window_valid), 128'd0);
        end else begin
          e = sb_q.pop_front();
          chk_win("window", window, e.w);
          chk("metadata", 128'(metadata), 128'(e.m));
        end
        last_win = window;
        if (!chk_period) have_prev = 0;
        else begin
          if (have_prev) chk("period", 128'(cyc - last_hs), 128'd10);
          have_prev = 1;
        end
        last_hs = cyc;
      end
      if (stream_valid && stream_ready) begin
        if (m_idx == 0) m_meta0 = stream[127:124];
        else if (stream[127:124] != m_meta0) exp_err = 1;
        if (m_idx == 9) begin
          chk("valid_pre", 128'(window_valid), 128'd0);
          exp_valid = 1;
          m_idx = 0;
        end else m_idx++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[5];
    logic [1151:0] w, w2, held_w;
    logic [3:0]    held_m;
    int            errs0;
    exp_t          e;

    vecs[0] = '{meta: 4'h5, bad_k: -1, bad_meta: 4'h0, pad: 1'b0, exp_errs: 0};
    vecs[1] = '{meta: 4'h2, bad_k: 3,  bad_meta: 4'hA, pad: 1'b0, exp_errs: 1};
    vecs[2] = '{meta: 4'h7, bad_k: 9,  bad_meta: 4'h0, pad: 1'b0, exp_errs: 1};
    vecs[3] = '{meta: 4'hF, bad_k: 1,  bad_meta: 4'hE, pad: 1'b1, exp_errs: 1};
    vecs[4] = '{meta: 4'h3, bad_k: -1, bad_meta: 4'h0, pad: 1'b1, exp_errs: 0};

    rst = 1'b0;
    stream_valid = 1'b0;
    stream = '0;
    window_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_stream_ready", 128'(stream_ready), 128'd1);
    chk("rst_window_valid", 128'(window_valid), 128'd0);
    chk("rst_meta_error", 128'(meta_error), 128'd0);
    chk("rst_metadata", 128'(metadata), 128'd0);
    chk_win("rst_window", window, '0);
    @(posedge clk);
    #1;

    // Round trip and metadata-mismatch vectors
    window_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      w = rand_win();
      e.w = w;
      e.m = vecs[v].meta;
      sb_q.push_back(e);
      errs0 = err_pulses;
      send_window(w, vecs[v].meta, 0, 9, vecs[v].bad_k, vecs[v].bad_meta, vecs[v].pad);
      stream_valid = 1'b0;
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("err_pulses_v%0d", v), 128'(err_pulses - errs0), 128'(vecs[v].exp_errs));
    end

    // Continuous streaming: 5 windows back to back, metadata 0..4
    chk_period = 1;
    for (int n = 0; n < 5; n++) begin
      w = rand_win();
      e.w = w;
      e.m = 4'(n);
      sb_q.push_back(e);
      send_window(w, 4'(n), 0, 9, -1, 4'h0, 1'b0);
    end
    stream_valid = 1'b0;
    wait_drain();
    chk_period = 0;
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure with overlap handoff
    window_ready = 1'b0;
    w = rand_win();
    w2 = rand_win();
    e.w = w;  e.m = 4'h9; sb_q.push_back(e);
    e.w = w2; e.m = 4'h6; sb_q.push_back(e);
    send_window(w, 4'h9, 0, 9, -1, 4'h0, 1'b0);
    stream_valid = 1'b1;
    stream = mk_beat(w2, 4'h6, 0, 1'b0);
    @(negedge clk);
    held_w = window;
    held_m = metadata;
    chk_win("bp_window_first", held_w, w);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_stream_ready", 128'(stream_ready), 128'd0);
      chk("bp_window_valid", 128'(window_valid), 128'd1);
      chk_win("bp_window_stable", window, held_w);
      chk("bp_meta_stable", 128'(metadata), 128'(held_m));
    end
    @(posedge clk);
    #1 window_ready = 1'b1;
    @(negedge clk);
    chk("bp_overlap_ready", 128'(stream_ready), 128'd1);
    @(posedge clk);
    #1;
    send_window(w2, 4'h6, 1, 9, -1, 4'h0, 1'b0);
    stream_valid = 1'b0;
    wait_drain();
    repeat (2) @(posedge clk);
    #1;

    // Mid-window reset, then a padded fresh window
    w = rand_win();
    send_window(w, 4'hC, 0, 6, -1, 4'h0, 1'b0);
    stream_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_window_valid", 128'(window_valid), 128'd0);
    chk("mrst_metadata", 128'(metadata), 128'd0);
    chk_win("mrst_window", window, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    w2 = rand_win();
    e.w = w2;
    e.m = 4'h1;
    sb_q.push_back(e);
    send_window(w2, 4'h1, 0, 9, -1, 4'h0, 1'b1);
    stream_valid = 1'b0;
    wait_drain();
    stream = mk_beat(w2, 4'h1, 9, 1'b1);
    chk("pad_top_bits", 128'(last_win[1151:1116]), 128'(stream[35:0]));
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 128'(sb_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/window_deserializer.md
# window_deserializer

Receive-side counterpart of `window_serializer`. It accepts the 128-bit beat stream (metadata + data slice per beat), reassembles each 10-beat sequence into a full 1152-bit HOG detection window with its 4-bit metadata (pyramid level), and presents the window on a valid/ready interface to the downstream classifier. It also checks that every beat of a window carries the same metadata.

## Interface
Parameters:
- `WINDOW_WIDTH`, default 1152: reassembled window width in bits.
- `BUS_WIDTH`, default 128: stream beat width.
- `META_WIDTH`, default 4: metadata field carried in every beat.
- Derived, not overridable:
  - `DATA_PORTION` = `BUS_WIDTH - META_WIDTH` (124).
  - `BEATS` = ceil(`WINDOW_WIDTH` / `DATA_PORTION`) (10).
  - `REMAIN` = `WINDOW_WIDTH - (BEATS-1)*DATA_PORTION` (36).
  - Counter width = `$clog2(BEATS)`.

Ports:
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stream_valid`  in  1  upstream beat valid.
- `stream`  in  `BUS_WIDTH`  beat. `stream[BUS_WIDTH-1 -: META_WIDTH]` is metadata; `stream[DATA_PORTION-1:0]` is data.
- `stream_ready`  out  1  beat accept.
- `window_valid`  out  1  reassembled window available.
- `window_ready`  in  1  downstream accept.
- `window`  out  `WINDOW_WIDTH`  reassembled window.
- `metadata`  out  `META_WIDTH`  metadata latched from beat 0.
- `meta_error`  out  1  one-cycle pulse when a beat's metadata differs from beat 0.

## Operation
- Beat k (0..BEATS-1) data lands in `window[k*DATA_PORTION +: DATA_PORTION]`.
- Last beat: only `stream[REMAIN-1:0]` is used. Bits `[DATA_PORTION-1:REMAIN]` are ignored (padding).
- A beat is accepted on `stream_valid && stream_ready`.
- States:
  - COLLECT:
    - `stream_ready`=1, `window_valid`=0.
    - Each accepted beat writes its slice and increments `beat_cnt`.
    - Beat 0 also latches `metadata`.
    - When beat `BEATS-1` is accepted: `beat_cnt` goes to 0 and the state goes to FULL.
  - FULL:
    - `window_valid`=1. `window` and `metadata` are held stable.
    - `stream_ready` = `window_ready` (overlap path).
    - On `window_ready`=1 with no beat accepted: go to COLLECT, `beat_cnt`=0.
    - On `window_ready`=1 with `stream_valid`=1: window handshake and beat 0 acceptance happen in the same cycle. Slice 0 and `metadata` take the new beat, the state goes to COLLECT, and `beat_cnt`=1.
    - On `window_ready`=0: nothing changes. Upstream is back-pressured.
- Metadata check:
  - Applies to beats 1..BEATS-1, compared against the latched beat-0 metadata.
  - On mismatch, `meta_error` pulses 1 the cycle after that beat is accepted.
  - The window is still completed and delivered with the beat-0 metadata. There is no resynchronisation.
- `beat_cnt` never exceeds `BEATS-1`. It wraps to 0 only via the last-beat rule.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - State = COLLECT, `beat_cnt`=0.
  - `stream_ready`=1, `window_valid`=0, `meta_error`=0.
  - `window`=0, `metadata`=0.
- Reset mid-window discards the partial window. The next accepted beat is treated as beat 0.
- `window_valid` rises the cycle after the 10th beat handshake. There is no combinational path from `stream` to `window`.
- `stream_ready` is the only combinational output (FULL state: equals `window_ready`). All other outputs are registered.
- Throughput: with `stream_valid` and `window_ready` held at 1, one window is produced every 10 cycles with no bubble.
- AXI-style rules apply: once asserted, `window_valid` stays high and `window`/`metadata` stay stable until `window_ready`.
- Gaps in `stream_valid` between beats are legal and do not reset `beat_cnt`.

## Test plan
- Reset: drive `rst`=0 for 2 cycles, then 1. Required: `stream_ready`=1, `window_valid`=0, `meta_error`=0, `window`=0 before any beat.
- Round trip:
  - Feed `window_serializer` with a window of `{36{$random}}` and metadata 4'h5, then connect it to this block with `window_ready`=1.
  - Required: the output window is bit-identical, `metadata`=4'h5, and `window_valid` rises exactly 1 cycle after the 10th beat.
- Back-pressure:
  - Hold `window_ready`=0 for 20 cycles after a window completes, with `stream_valid`=1.
  - Required: `stream_ready`=0, and `window`/`metadata` are stable for those 20 cycles.
  - Then raise `window_ready`. Required: beat 0 of the next window is accepted in the same cycle.
- Continuous streaming: 5 back-to-back windows (metadata 0..4), with `stream_valid` and `window_ready` constant 1. Required: `window_valid` pulses every 10 cycles and every window matches its source.
- Meta mismatch:
  - Send beat 3 with metadata 4'hA while beat 0 carries 4'h2.
  - Required: `meta_error`=1 for exactly 1 cycle, after beat 3 is accepted. The window is delivered with `metadata`=4'h2.
- Mid-window reset and padding:
  - Assert `rst` after beat 6, then send a fresh 10-beat window whose last beat has padding bits set to 1.
  - Required: only the fresh window is output, and `window[1151:1116]` equals the last beat's `[35:0]`.
